instr_fetch_decode: RTL and testbench

//  Fetch/decode stage feeding the register-file + ALU execute stage. Holds the PC, fetches
//  32-bit MIPS-style R-type words from instruction memory over a req/valid interface,

---
 rtl/instr_fetch_decode_pkg.sv | 35 +++
 rtl/instr_fetch_decode_r_type_decoder.sv | 43 ++++
 rtl/instr_fetch_decode.sv | 111 +++++++++++
 tb/tb_instr_fetch_decode.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode stage: FSM state codes, R-type opcode/funct
// values and the ALU control codes understood by the execute stage.
package instr_fetch_decode_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_ISSUE = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [3:0] alu_ctrl;
      logic       legal;
      logic       is_halt;
   } decode_t;

endpackage

// File: rtl/instr_fetch_decode_r_type_decoder.sv
// Combinational R-type decoder: splits the instruction word into register fields and
// maps funct to an ALU control code; flags HALT and words outside the supported set.
module instr_fetch_decode_r_type_decoder
   import instr_fetch_decode_pkg::*;
(
   input  logic [31:0] instr,
   output decode_t     dec
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       funct_ok;
   logic [3:0] alu_code;
   logic       unused_shamt;

   assign opcode       = instr[31:26];
   assign funct        = instr[5:0];
   assign unused_shamt = ^instr[10:6];

   always_comb begin
      funct_ok = 1'b1;
      alu_code = ALU_AND;
      case (funct)
         FUNCT_ADD: alu_code = ALU_ADD;
         FUNCT_SUB: alu_code = ALU_SUB;
         FUNCT_AND: alu_code = ALU_AND;
         FUNCT_OR:  alu_code = ALU_OR;
         FUNCT_SLT: alu_code = ALU_SLT;
         default:   funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      dec          = '0;
      dec.rs       = instr[25:21];
      dec.rt       = instr[20:16];
      dec.rd       = instr[15:11];
      dec.alu_ctrl = alu_code;
      dec.is_halt  = (opcode == OP_HALT);
      dec.legal    = (opcode == OP_RTYPE) && funct_ok;
   end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: owns the PC, fetches one word at a time over imem req/valid,
// decodes it and hands R-type ops to execute; stops for good on HALT.
module instr_fetch_decode
   import instr_fetch_decode_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_valid,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [4:0]        src_reg1,
   output logic [4:0]        src_reg2,
   output logic [4:0]        dest_reg,
   output logic [3:0]        alu_ctrl,
   output logic [ADDR_W-1:0] pc_out,
   output logic              illegal,
   output logic              halted,
   output logic [2:0]        state_dbg
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_nx;
   logic              capture;
   decode_t           dec;

   instr_fetch_decode_r_type_decoder u_dec (
      .instr (imem_rdata),
      .dec   (dec)
   );

   assign capture   = (state == ST_WAIT) && imem_valid;
   assign state_dbg = state;

   // Issue handshake: an op transfers on a cycle where issue_valid && issue_ready; until
   // then valid stays high and every issue field holds. Ready while not valid is ignored.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_FETCH;
         ST_FETCH: state_nx = ST_WAIT;
         ST_WAIT: begin
            if (imem_valid) begin
               if (dec.is_halt) begin
                  state_nx = ST_HALT;
               end else if (dec.legal) begin
                  state_nx = ST_ISSUE;
               end else begin
                  state_nx = ST_FETCH;
                  pc_nx    = pc + PC_STEP;
               end
            end
         end
         ST_ISSUE: begin
            if (issue_ready) begin
               state_nx = ST_FETCH;
               pc_nx    = pc + PC_STEP;
            end
         end
         ST_HALT:  state_nx = ST_HALT;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= '0;
         issue_valid <= 1'b0;
         src_reg1    <= '0;
         src_reg2    <= '0;
         dest_reg    <= '0;
         alu_ctrl    <= '0;
         pc_out      <= '0;
         illegal     <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         // Request is raised on entry to FETCH, which always lasts exactly one cycle.
         imem_req    <= (state_nx == ST_FETCH);
         issue_valid <= (state_nx == ST_ISSUE);
         illegal     <= capture && !dec.is_halt && !dec.legal;
         halted      <= halted || (state_nx == ST_HALT);
         if (state_nx == ST_FETCH) begin
            imem_addr <= pc_nx;
         end
         if (capture && dec.legal && !dec.is_halt) begin
            src_reg1 <= dec.rs;
            src_reg2 <= dec.rt;
            dest_reg <= dec.rd;
            alu_ctrl <= dec.alu_ctrl;
            pc_out   <= pc;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed + randomized bench for instr_fetch_decode with an instruction-level model.
module tb_instr_fetch_decode;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              imem_valid;
   logic              issue_valid;
   logic              issue_ready;
   logic [4:0]        src_reg1;
   logic [4:0]        src_reg2;
   logic [4:0]        dest_reg;
   logic [3:0]        alu_ctrl;
   logic [ADDR_W-1:0] pc_out;
   logic              illegal;
   logic              halted;
   logic [2:0]        state_dbg;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned exp_pc   = 0;
   logic [31:0] exp_q[$];
   logic [5:0]  functs[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

   instr_fetch_decode #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .src_reg1    (src_reg1),
      .src_reg2    (src_reg2),
      .dest_reg    (dest_reg),
      .alu_ctrl    (alu_ctrl),
      .pc_out      (pc_out),
      .illegal     (illegal),
      .halted      (halted),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction-level meaning: -2 halt, -1 illegal, otherwise the ALU control code.
   function automatic int model_decode(input logic [31:0] w);
      if (w[31:26] == 6'h3F) return -2;
      if (w[31:26] != 6'h00) return -1;
      case (w[5:0])
         6'h20:   return 2;
         6'h22:   return 6;
         6'h24:   return 0;
         6'h25:   return 1;
         6'h2A:   return 7;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] issue_pack();
      return {5'b0, pc_out, src_reg1, src_reg2, dest_reg, alu_ctrl};
   endfunction

   function automatic logic [31:0] all_outputs();
      return {imem_req, issue_valid, illegal, halted, imem_addr, src_reg1 ^ src_reg2 ^ dest_reg,
              alu_ctrl, pc_out};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_outputs", all_outputs(), 32'h0);
      chk("reset_fields", {17'b0, src_reg1, src_reg2, dest_reg}, 32'h0);
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = 0;
      exp_q.delete();
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_req", {31'b0, imem_req}, 32'h1);
   endtask

   // Serves one fetch: waits for the request, answers after lat cycles, then checks the
   // stage's reaction and, for a legal op, holds issue_ready low for stall cycles.
   task automatic do_fetch(input logic [31:0] w, input int lat, input int stall);
      int          tries = 0;
      int          code;
      logic [31:0] exp_pack;
      while (imem_req !== 1'b1 && tries < 10) begin
         @(negedge clk);
         tries++;
      end
      chk("req_seen", {31'b0, imem_req}, 32'h1);
      if (imem_req !== 1'b1) return;
      chk("imem_addr", {24'b0, imem_addr}, exp_pc);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         issue_ready = 1'($urandom_range(0, 1));
         if (i == 0) begin
            chk("req_pulse", {31'b0, imem_req}, 32'h0);
            chk("illegal_pulse", {31'b0, illegal}, 32'h0);
         end
      end
      imem_valid = 1'b1;
      imem_rdata = w;
      @(negedge clk);
      imem_valid  = 1'b0;
      imem_rdata  = $urandom;
      issue_ready = 1'b0;
      code = model_decode(w);
      if (code == -2) begin
         chk("halt_halted", {31'b0, halted}, 32'h1);
         chk("halt_no_issue", {31'b0, issue_valid}, 32'h0);
         chk("halt_no_req", {31'b0, imem_req}, 32'h0);
      end else if (code == -1) begin
         chk("illegal_flag", {31'b0, illegal}, 32'h1);
         chk("illegal_no_issue", {31'b0, issue_valid}, 32'h0);
         chk("illegal_refetch", {31'b0, imem_req}, 32'h1);
         exp_pc = (exp_pc + 4) % (1 << ADDR_W);
      end else begin
         exp_q.push_back({5'b0, exp_pc[7:0], w[25:21], w[20:16], w[15:11], code[3:0]});
         chk("issue_valid", {31'b0, issue_valid}, 32'h1);
         exp_pack = exp_q.pop_front();
         chk("issue_fields", issue_pack(), exp_pack);
         for (int i = 0; i < stall; i++) begin
            imem_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_valid", {31'b0, issue_valid}, 32'h1);
            chk("stall_fields", issue_pack(), exp_pack);
            chk("stall_no_req", {31'b0, imem_req}, 32'h0);
         end
         imem_valid  = 1'b0;
         issue_ready = 1'b1;
         @(negedge clk);
         issue_ready = 1'b0;
         chk("handshake_drop", {31'b0, issue_valid}, 32'h0);
         chk("handshake_fetch", {31'b0, imem_req}, 32'h1);
         exp_pc = (exp_pc + 4) % (1 << ADDR_W);
      end
   endtask

   function automatic logic [31:0] rand_word();
      int          r;
      logic [31:0] w;
      logic [5:0]  f;
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r < 7) begin
         w[31:26] = 6'h00;
         w[5:0]   = functs[$urandom_range(0, 4)];
      end else if (r < 9) begin
         w[31:26] = 6'h00;
         f = 6'($urandom_range(0, 63));
         while (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A)
            f = 6'($urandom_range(0, 63));
         w[5:0] = f;
      end else begin
         w[31:26] = 6'($urandom_range(1, 62));
      end
      return w;
   endfunction

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      imem_valid  = 1'b0;
      issue_ready = 1'b0;
      imem_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      chk("reset_initial", all_outputs(), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset while waiting for imem, then a late response that must be ignored.
      do_start();
      @(negedge clk);
      do_reset();
      imem_valid = 1'b1;
      imem_rdata = 32'h00221820;
      @(negedge clk);
      imem_valid = 1'b0;
      chk("stray_no_issue", {31'b0, issue_valid}, 32'h0);
      chk("stray_no_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk);
      chk("stray_idle_outputs", all_outputs(), 32'h0);

      // add at PC 0, then a long stall on the next op at PC 4.
      do_start();
      do_fetch(32'h00221820, 1, 0);
      do_fetch(32'h00221820, 1, 10);

      do_reset();
      do_start();
      do_fetch(32'h00221822, 1, 2);
      do_fetch(32'h0022182A, 2, 0);
      do_fetch(32'h0022183B, 1, 0);
      do_fetch(32'h00221824, 3, 0);
      do_fetch(32'h00221825, 1, 1);
      do_fetch(32'hFC000000, 1, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("halt_idle_req", {30'b0, imem_req, halted}, 32'h1);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("halt_start_ignored", {29'b0, imem_req, issue_valid, halted}, 32'h1);
      end

      // Random program long enough to wrap the PC past 8'hFC, ending in HALT.
      do_reset();
      do_start();
      for (int k = 0; k < 80; k++) begin
         do_fetch(rand_word(), $urandom_range(1, 3), $urandom_range(0, 3));
      end
      do_fetch(32'hFC000000, $urandom_range(1, 3), 0);
      chk("scoreboard_empty", exp_q.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
